// File: rtl/ex_pkg.sv
// Shared definitions for the RV32I execute stage.
// Holds opcodes, EX/MEM select codes, ALU/multiplier enums, the EX/MEM payload
// struct and the funct3-to-ALU-op decode helper.
package ex_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RA_W = 5;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;

  localparam logic [2:0] SEL_NORMAL = 3'b001;
  localparam logic [2:0] SEL_FLUSH  = 3'b010;
  localparam logic [2:0] SEL_STALL  = 3'b100;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_MUL, ALU_ZERO
  } alu_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] rs2;
    logic [XLEN-1:0] inst;
  } ex_mem_t;

  // SUB only exists for register-register ops; bit 30 picks SRA for both forms.
  function automatic alu_op_e f3_alu_op(input logic [2:0] f3, input logic alt,
                                        input logic is_reg);
    case (f3)
      3'b000:  return (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/ex_mul.sv
// Iterative 32-cycle unsigned shift-add multiplier (low 32 product bits).
// Built only when EX_MUL_EN is defined.
// Ports: clk_i, reset_i (sync, active-high), start_i, abort_i, a_i, b_i,
//        busy_o (start cycle in IDLE and all of BUSY), done_o (DONE state),
//        product_o (valid while done_o).
module ex_mul import ex_pkg::*; (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int unsigned CNT_W = 5;

  mul_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

  // Next state and one shift-add step per BUSY cycle
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          state_d  = BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = a_i;
          mplier_d = b_i;
        end
      end
      BUSY: begin
        if (abort_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(31)) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Status outputs
  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (state_q)
      IDLE:    busy_o = start_i;
      BUSY:    busy_o = 1'b1;
      DONE:    done_o = 1'b1;
      default: ;
    endcase
  end

  assign product_o = acc_q;

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: forwarding, immediates, ALU, branch resolution and
// the EX/MEM pipeline register. Define EX_MUL_EN to add the iterative MUL.
// Ports: clk, reset (sync, active-high); pc_Ex/inst_Ex/rs1_Ex/rs2_Ex from
// decode; reg_mux_sel (001 normal, 010 flush, 100 stall, else hold);
// MEM/WB forwarding sources; *_Mem registered outputs; br_taken/br_target and
// mul_busy are combinational.
module ex_stage import ex_pkg::*; (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] pc_Ex,
  input  logic [XLEN-1:0] inst_Ex,
  input  logic [XLEN-1:0] rs1_Ex,
  input  logic [XLEN-1:0] rs2_Ex,
  input  logic [2:0]      reg_mux_sel,
  input  logic            reg_write_en_Mem,
  input  logic            reg_write_en_Wb,
  input  logic [XLEN-1:0] wb_mux_out_Wb,
  input  logic [XLEN-1:0] inst_Wb,
  output logic [XLEN-1:0] pc_Mem,
  output logic [XLEN-1:0] alu_Mem,
  output logic [XLEN-1:0] rs2_Mem,
  output logic [XLEN-1:0] inst_Mem,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            mul_busy
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_fwd, rs2_fwd;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [XLEN-1:0] op_a, op_b, alu_res;
  alu_op_e         alu_op;
  ex_mem_t         ex_mem_q, ex_mem_d;
  logic            unused_inst_wb;

  assign opcode = inst_Ex[6:0];
  assign funct3 = inst_Ex[14:12];
  assign unused_inst_wb = ^{inst_Wb[31:12], inst_Wb[6:0]};

  // MEM result wins over WB; x0 never forwards
  function automatic logic [XLEN-1:0] fwd(input logic [RA_W-1:0] addr,
                                          input logic [XLEN-1:0] reg_val);
    if (addr == '0)                                         return reg_val;
    else if (reg_write_en_Mem && (ex_mem_q.inst[11:7] == addr)) return ex_mem_q.alu;
    else if (reg_write_en_Wb && (inst_Wb[11:7] == addr))       return wb_mux_out_Wb;
    else                                                    return reg_val;
  endfunction

  assign rs1_fwd = fwd(inst_Ex[19:15], rs1_Ex);
  assign rs2_fwd = fwd(inst_Ex[24:20], rs2_Ex);

  assign imm_i = {{20{inst_Ex[31]}}, inst_Ex[31:20]};
  assign imm_s = {{20{inst_Ex[31]}}, inst_Ex[31:25], inst_Ex[11:7]};
  assign imm_b = {{19{inst_Ex[31]}}, inst_Ex[31], inst_Ex[7], inst_Ex[30:25],
                  inst_Ex[11:8], 1'b0};
  assign imm_u = {inst_Ex[31:12], 12'h000};
  assign imm_j = {{11{inst_Ex[31]}}, inst_Ex[31], inst_Ex[19:12], inst_Ex[20],
                  inst_Ex[30:21], 1'b0};

  // Operand and operation select
  always_comb begin
    alu_op = ALU_ZERO;
    op_a   = '0;
    op_b   = '0;
    case (opcode)
      OP: begin
        op_a = rs1_fwd;
        op_b = rs2_fwd;
        if (inst_Ex[31:25] == 7'b0000001) begin
`ifdef EX_MUL_EN
          if (funct3 == 3'b000) alu_op = ALU_MUL;
`endif
        end else begin
          alu_op = f3_alu_op(funct3, inst_Ex[30], 1'b1);
        end
      end
      OP_IMM: begin
        op_a   = rs1_fwd;
        op_b   = imm_i;
        alu_op = f3_alu_op(funct3, inst_Ex[30], 1'b0);
      end
      LOAD:  begin op_a = rs1_fwd; op_b = imm_i;    alu_op = ALU_ADD; end
      STORE: begin op_a = rs1_fwd; op_b = imm_s;    alu_op = ALU_ADD; end
      LUI:   begin op_a = '0;      op_b = imm_u;    alu_op = ALU_ADD; end
      AUIPC: begin op_a = pc_Ex;   op_b = imm_u;    alu_op = ALU_ADD; end
      JAL,
      JALR:  begin op_a = pc_Ex;   op_b = XLEN'(4); alu_op = ALU_ADD; end
      default: ;
    endcase
  end

`ifdef EX_MUL_EN
  logic            mul_start, mul_abort, mul_done;
  logic [XLEN-1:0] mul_product;

  assign mul_start = (alu_op == ALU_MUL) && (reg_mux_sel == SEL_NORMAL);
  assign mul_abort = (reg_mux_sel == SEL_FLUSH);

  ex_mul u_ex_mul (
    .clk_i     (clk),
    .reset_i   (reset),
    .start_i   (mul_start),
    .abort_i   (mul_abort),
    .a_i       (rs1_fwd),
    .b_i       (rs2_fwd),
    .busy_o    (mul_busy),
    .done_o    (mul_done),
    .product_o (mul_product)
  );
`else
  assign mul_busy = 1'b0;
`endif

  // ALU
  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_SLL:  alu_res = op_a << op_b[4:0];
      ALU_SLT:  alu_res = {31'b0, $signed(op_a) < $signed(op_b)};
      ALU_SLTU: alu_res = {31'b0, op_a < op_b};
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SRL:  alu_res = op_a >> op_b[4:0];
      ALU_SRA:  alu_res = XLEN'($signed(op_a) >>> op_b[4:0]);
      ALU_OR:   alu_res = op_a | op_b;
      ALU_AND:  alu_res = op_a & op_b;
`ifdef EX_MUL_EN
      ALU_MUL:  alu_res = mul_done ? mul_product : '0;
`endif
      default:  alu_res = '0;
    endcase
  end

  // Branch / jump resolution
  always_comb begin
    br_taken  = 1'b0;
    br_target = pc_Ex + XLEN'(4);
    case (opcode)
      BRANCH: begin
        case (funct3)
          3'b000:  br_taken = (rs1_fwd == rs2_fwd);
          3'b001:  br_taken = (rs1_fwd != rs2_fwd);
          3'b100:  br_taken = ($signed(rs1_fwd) <  $signed(rs2_fwd));
          3'b101:  br_taken = ($signed(rs1_fwd) >= $signed(rs2_fwd));
          3'b110:  br_taken = (rs1_fwd <  rs2_fwd);
          3'b111:  br_taken = (rs1_fwd >= rs2_fwd);
          default: br_taken = 1'b0;
        endcase
        if (br_taken) br_target = pc_Ex + imm_b;
      end
      JAL: begin
        br_taken  = 1'b1;
        br_target = pc_Ex + imm_j;
      end
      JALR: begin
        br_taken  = 1'b1;
        br_target = (rs1_fwd + imm_i) & ~XLEN'(1);
      end
      default: ;
    endcase
  end

  // EX/MEM next value; a multiply in progress holds the register
  always_comb begin
    ex_mem_d = ex_mem_q;
    case (reg_mux_sel)
      SEL_NORMAL: begin
        if (!mul_busy) begin
          ex_mem_d.pc   = pc_Ex;
          ex_mem_d.alu  = alu_res;
          ex_mem_d.rs2  = rs2_fwd;
          ex_mem_d.inst = inst_Ex;
        end
      end
      SEL_FLUSH: ex_mem_d = '0;
      SEL_STALL: ex_mem_d = ex_mem_q;
      default:   ex_mem_d = ex_mem_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) ex_mem_q <= '0;
    else       ex_mem_q <= ex_mem_d;
  end

  assign pc_Mem   = ex_mem_q.pc;
  assign alu_Mem  = ex_mem_q.alu;
  assign rs2_Mem  = ex_mem_q.rs2;
  assign inst_Mem = ex_mem_q.inst;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus randomized traffic
// against a behavioural model of the execute stage and EX/MEM register.
module tb_ex_stage;

  localparam logic [2:0] S_N = 3'b001;
  localparam logic [2:0] S_F = 3'b010;
  localparam logic [2:0] S_S = 3'b100;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_Ex, inst_Ex, rs1_Ex, rs2_Ex;
  logic [2:0]  reg_mux_sel;
  logic        reg_write_en_Mem, reg_write_en_Wb;
  logic [31:0] wb_mux_out_Wb, inst_Wb;
  logic [31:0] pc_Mem, alu_Mem, rs2_Mem, inst_Mem;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mul_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the EX/MEM register
  logic [31:0] m_pc, m_alu, m_rs2, m_inst;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk              (clk),
    .reset            (reset),
    .pc_Ex            (pc_Ex),
    .inst_Ex          (inst_Ex),
    .rs1_Ex           (rs1_Ex),
    .rs2_Ex           (rs2_Ex),
    .reg_mux_sel      (reg_mux_sel),
    .reg_write_en_Mem (reg_write_en_Mem),
    .reg_write_en_Wb  (reg_write_en_Wb),
    .wb_mux_out_Wb    (wb_mux_out_Wb),
    .inst_Wb          (inst_Wb),
    .pc_Mem           (pc_Mem),
    .alu_Mem          (alu_Mem),
    .rs2_Mem          (rs2_Mem),
    .inst_Mem         (inst_Mem),
    .br_taken         (br_taken),
    .br_target        (br_target),
    .mul_busy         (mul_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sx(input int w, input logic [31:0] v);
    logic signed [31:0] t;
    t = v << (32 - w);
    return t >>> (32 - w);
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction

  // Register value seen by EX after MEM/WB bypass, MEM taking precedence
  function automatic logic [31:0] fwd(input logic [4:0] a, input logic [31:0] regv);
    if (a == 5'd0) return regv;
    if (reg_write_en_Mem && m_inst[11:7] == a) return m_alu;
    if (reg_write_en_Wb && inst_Wb[11:7] == a) return wb_mux_out_Wb;
    return regv;
  endfunction

  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic [31:0] a,
      input logic [31:0] b, input logic alt, input logic is_reg);
    int unsigned sh;
    sh = b % 32;
    case (f3)
      3'd0:    return (alt && is_reg) ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3:    return (a < b) ? 32'd1 : 32'd0;
      3'd4:    return a ^ b;
      3'd5:    return alt ? 32'($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic model(output logic [31:0] res, output logic tk, output logic [31:0] tgt,
                       output logic [31:0] st);
    logic [31:0] a, b, ii, is, ib, iu, ij, inst;
    logic [2:0]  f3;
    logic        c;
    inst = inst_Ex;
    f3 = inst[14:12];
    a  = fwd(inst[19:15], rs1_Ex);
    b  = fwd(inst[24:20], rs2_Ex);
    ii = sx(12, {20'd0, inst[31:20]});
    is = sx(12, {20'd0, inst[31:25], inst[11:7]});
    ib = sx(13, {19'd0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
    iu = {inst[31:12], 12'd0};
    ij = sx(21, {11'd0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
    res = 32'd0; tk = 1'b0; tgt = pc_Ex + 32'd4; st = b; c = 1'b0;
    case (inst[6:0])
      7'h33: res = (inst[31:25] == 7'd1) ? 32'd0 : alu_ref(f3, a, b, inst[30], 1'b1);
      7'h13: res = alu_ref(f3, a, ii, inst[30], 1'b0);
      7'h03: res = a + ii;
      7'h23: res = a + is;
      7'h37: res = iu;
      7'h17: res = pc_Ex + iu;
      7'h6f: begin res = pc_Ex + 32'd4; tk = 1'b1; tgt = pc_Ex + ij; end
      7'h67: begin res = pc_Ex + 32'd4; tk = 1'b1; tgt = (a + ii) & 32'hFFFF_FFFE; end
      7'h63: begin
        case (f3)
          3'd0: c = (a == b);
          3'd1: c = (a != b);
          3'd4: c = ($signed(a) < $signed(b));
          3'd5: c = ($signed(a) >= $signed(b));
          3'd6: c = (a < b);
          3'd7: c = (a >= b);
          default: c = 1'b0;
        endcase
        if (c) begin tk = 1'b1; tgt = pc_Ex + ib; end
      end
      default: ;
    endcase
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] r1,
      input logic [31:0] r2, input logic [2:0] sel, input logic wem, input logic wew,
      input logic [31:0] wbd, input logic [31:0] iwb);
    pc_Ex = pc; inst_Ex = inst; rs1_Ex = r1; rs2_Ex = r2; reg_mux_sel = sel;
    reg_write_en_Mem = wem; reg_write_en_Wb = wew; wb_mux_out_Wb = wbd; inst_Wb = iwb;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_pc"},   pc_Mem,   m_pc);
    check({tag, "_alu"},  alu_Mem,  m_alu);
    check({tag, "_rs2"},  rs2_Mem,  m_rs2);
    check({tag, "_inst"}, inst_Mem, m_inst);
  endtask

  // One non-MUL cycle: called just after a negedge with inputs applied
  task automatic step(input string tag);
    logic [31:0] r, t, s;
    logic        tk;
    logic [2:0]  sel;
    model(r, tk, t, s);
    sel = reg_mux_sel;
    #1;
    check({tag, "_tk"},   32'(br_taken), 32'(tk));
    check({tag, "_tgt"},  br_target, t);
    check({tag, "_busy"}, 32'(mul_busy), 32'd0);
    @(posedge clk);
    if (sel == S_N) begin
      m_pc = pc_Ex; m_alu = r; m_rs2 = s; m_inst = inst_Ex;
    end else if (sel == S_F) begin
      m_pc = '0; m_alu = '0; m_rs2 = '0; m_inst = '0;
    end
    @(negedge clk);
    check_regs(tag);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [4:0]  rd, a1, a2;
    r  = $urandom;
    rd = 5'($urandom_range(0, 3));
    a1 = 5'($urandom_range(0, 3));
    a2 = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 10))
      0:  return enc_r(r[0] ? 7'h20 : 7'h00, a2, a1, r[14:12], rd, 7'h33);
      1:  return enc_i(r[31:20], a1, r[14:12], rd, 7'h13);
      2:  return enc_i(r[31:20], a1, 3'd2, rd, 7'h03);
      3:  return {r[31:25], a2, a1, 3'd2, r[11:7], 7'h23};
      4:  return {r[31:25], a2, a1, r[14:12], r[11:7], 7'h63};
      5:  return {r[31:12], rd, 7'h6f};
      6:  return enc_i(r[31:20], a1, 3'd0, rd, 7'h67);
      7:  return {r[31:12], rd, 7'h37};
      8:  return {r[31:12], rd, 7'h17};
      9:  return 32'd0;
      default: return {r[31:7], 7'h0b};
    endcase
  endfunction

  logic [31:0] saved;
  logic [31:0] wb_i1, wb_i0, mul_i;
  int          busy_n;

  initial begin
    #200000;
    $display("FAIL timeout: got no end expected end of test");
    $fatal(1, "timeout");
  end

  initial begin
    wb_i1 = enc_i(12'h0, 5'd0, 3'd0, 5'd1, 7'h13);
    wb_i0 = enc_i(12'h0, 5'd0, 3'd0, 5'd0, 7'h13);
    mul_i = enc_r(7'h01, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33);

    // Reset for two edges with live inputs
    reset = 1'b1;
    set_in(32'h40, enc_r(7'h0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'd1, 32'd2, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    m_pc = '0; m_alu = '0; m_rs2 = '0; m_inst = '0;
    check_regs("reset");
    reset = 1'b0;
    set_in(32'h40, 32'd0, 32'd0, 32'd0, S_S, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("reset_tk", 32'(br_taken), 32'd0);
    check("reset_busy", 32'(mul_busy), 32'd0);
    @(negedge clk);

    // ADD x3,x1,x2
    set_in(32'h40, enc_r(7'h0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'd5, 32'd7, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    step("add");
    check("add_res", alu_Mem, 32'd12);

    // Forwarding priority: MEM, then WB, then register value
    set_in(32'h44, enc_i(12'h010, 5'd0, 3'd0, 5'd1, 7'h13), 32'd0, 32'd0, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    step("addi1");
    set_in(32'h48, enc_r(7'h0, 5'd0, 5'd1, 3'd0, 5'd3, 7'h33), 32'h99, 32'd0, S_N, 1'b1, 1'b1, 32'h20, wb_i1);
    step("fwd_mem");
    check("fwd_mem_res", alu_Mem, 32'h10);
    set_in(32'h44, enc_i(12'h010, 5'd0, 3'd0, 5'd1, 7'h13), 32'd0, 32'd0, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    step("addi2");
    set_in(32'h48, enc_r(7'h0, 5'd0, 5'd1, 3'd0, 5'd3, 7'h33), 32'h99, 32'd0, S_N, 1'b0, 1'b1, 32'h20, wb_i1);
    step("fwd_wb");
    check("fwd_wb_res", alu_Mem, 32'h20);
    set_in(32'h44, enc_i(12'h010, 5'd0, 3'd0, 5'd0, 7'h13), 32'd0, 32'd0, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    step("addi0");
    set_in(32'h48, enc_r(7'h0, 5'd0, 5'd1, 3'd0, 5'd3, 7'h33), 32'h99, 32'd0, S_N, 1'b1, 1'b1, 32'h20, wb_i0);
    step("fwd_x0");
    check("fwd_x0_res", alu_Mem, 32'h99);

    // Branches and JALR
    set_in(32'h100, enc_b(13'd8, 5'd6, 5'd5, 3'b100), 32'hFFFF_FFFF, 32'd1, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("blt_tk", 32'(br_taken), 32'd1);
    check("blt_tgt", br_target, 32'h108);
    step("blt");
    set_in(32'h100, enc_b(13'd8, 5'd6, 5'd5, 3'b110), 32'hFFFF_FFFF, 32'd1, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("bltu_tk", 32'(br_taken), 32'd0);
    check("bltu_tgt", br_target, 32'h104);
    step("bltu");
    set_in(32'h100, enc_i(12'h0, 5'd5, 3'd0, 5'd1, 7'h67), 32'h203, 32'd0, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("jalr_tgt", br_target, 32'h202);
    step("jalr");
    check("jalr_res", alu_Mem, 32'h104);

    // Stall, flush and undefined select codes
    saved = m_alu;
    for (int i = 0; i < 3; i++) begin
      set_in($urandom, rand_inst(), $urandom, $urandom, S_S, 1'b0, 1'b0, 32'd0, 32'd0);
      step("stall");
    end
    check("stall_hold", alu_Mem, saved);
    set_in(32'h200, enc_r(7'h0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'd1, 32'd2, S_F, 1'b0, 1'b0, 32'd0, 32'd0);
    step("flush");
    check("flush_inst", inst_Mem, 32'd0);
    set_in(32'h204, enc_r(7'h0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'd3, 32'd4, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    step("refill");
    saved = m_alu;
    set_in(32'h208, enc_r(7'h0, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33), 32'd30, 32'd40, 3'b011, 1'b0, 1'b0, 32'd0, 32'd0);
    step("sel011");
    check("sel011_hold", alu_Mem, saved);

`ifdef EX_MUL_EN
    // Full multiply: 33 busy cycles, result on the 34th edge
    set_in(32'h300, mul_i, 32'h12345, 32'h100, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    busy_n = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!mul_busy) break;
      busy_n++;
      @(posedge clk);
      @(negedge clk);
    end
    check("mul_busy_cycles", 32'(busy_n), 32'd33);
    check("mul_hold_alu", alu_Mem, m_alu);
    @(posedge clk);
    @(negedge clk);
    m_pc = 32'h300; m_alu = 32'h0123_4500; m_rs2 = 32'h100; m_inst = mul_i;
    check_regs("mul");
    set_in(32'h304, 32'd0, 32'd0, 32'd0, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    step("mul_after");

    // Abort in BUSY cycle 10
    set_in(32'h308, mul_i, 32'h12345, 32'h100, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (11) begin
      @(posedge clk);
      @(negedge clk);
    end
    #1;
    check("mul_busy_mid", 32'(mul_busy), 32'd1);
    reg_mux_sel = S_F;
    @(posedge clk);
    @(negedge clk);
    set_in(32'h30c, 32'd0, 32'd0, 32'd0, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    check("mul_abort_busy", 32'(mul_busy), 32'd0);
    m_pc = '0; m_alu = '0; m_rs2 = '0; m_inst = '0;
    check_regs("mul_abort");
    @(negedge clk);
`else
    // Without the multiplier a MUL encoding yields 0 in one cycle
    set_in(32'h300, mul_i, 32'h12345, 32'h100, S_N, 1'b0, 1'b0, 32'd0, 32'd0);
    step("mul_off");
    check("mul_off_res", alu_Mem, 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic [31:0] r1, r2, iw, pc;
      logic [2:0]  sel;
      int          k;
      r1 = $urandom;
      r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom;
      iw = $urandom;
      iw[11:7] = 5'($urandom_range(0, 3));
      pc = $urandom;
      pc[1:0] = 2'b00;
      k = $urandom_range(0, 9);
      sel = (k < 6) ? S_N : (k == 6) ? S_F : (k == 7) ? S_S : (k == 8) ? 3'b011 : 3'($urandom_range(0, 7));
      set_in(pc, rand_inst(), r1, r2, sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, iw);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
